// File: rtl/apb_pkg.sv
// Shared types and helpers for the APB master bridge: FSM state encoding,
// default bus widths and the slave-select width function.
package apb_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETUP  = 2'd1,
    ACCESS = 2'd2
  } apb_state_e;

  localparam int APB_ADDR_WIDTH = 32;
  localparam int APB_DATA_WIDTH = 32;

  // A single completer needs no select bits at all.
  function automatic int sel_width(input int n);
    return (n > 1) ? $clog2(n) : 0;
  endfunction

endpackage

// File: rtl/apb_addr_decoder.sv
// Combinational slave decode: the top SEL_W address bits pick the completer;
// indices at or beyond NUM_SLAVES flag a decode error and select nobody.
module apb_addr_decoder
  import apb_pkg::*;
#(
  parameter int ADDR_WIDTH = APB_ADDR_WIDTH,
  parameter int NUM_SLAVES = 4,
  parameter int IDX_W      = (sel_width(NUM_SLAVES) > 0) ? sel_width(NUM_SLAVES) : 1
) (
  input  logic [ADDR_WIDTH-1:0] addr,
  output logic [IDX_W-1:0]      idx,
  output logic [NUM_SLAVES-1:0] onehot,
  output logic                  dec_err
);

  localparam int SEL_W = sel_width(NUM_SLAVES);

  // Only the top bits matter; the rest of the address is deliberately ignored.
  logic unused_addr;
  assign unused_addr = ^addr;

  generate
    if (SEL_W == 0) begin : g_single
      assign idx     = '0;
      assign dec_err = 1'b0;
    end else begin : g_multi
      assign idx     = addr[ADDR_WIDTH-1 -: SEL_W];
      assign dec_err = (32'(idx) >= 32'(NUM_SLAVES));
    end
  endgenerate

  always_comb begin
    onehot = '0;
    for (int k = 0; k < NUM_SLAVES; k++) begin
      onehot[k] = !dec_err && (idx == k[IDX_W-1:0]);
    end
  end

endmodule

// File: rtl/apb_master_bridge.sv
// APB3 master bridge: one request at a time, per-slave select decode, done/error
// return path. Define APB_TIMEOUT_EN to abort ACCESS after TIMEOUT_CYCLES waits.
//
// Handshake: the requester presents trans_i with addr_i/wdata_i/wr_rd_i and must
// hold them until a cycle with ready_o=1; that cycle accepts the request. Each
// accepted request yields exactly one single-cycle done_o pulse, with trans_err_o
// and (for error-free reads) rdata_o valid in that same cycle.
module apb_master_bridge
  import apb_pkg::*;
#(
  parameter int ADDR_WIDTH     = APB_ADDR_WIDTH,
  parameter int DATA_WIDTH     = APB_DATA_WIDTH,
  parameter int NUM_SLAVES     = 4,
  parameter int TIMEOUT_CYCLES = 256
) (
  input  logic                             pclk,
  input  logic                             preset_n,
  input  logic                             trans_i,
  input  logic [ADDR_WIDTH-1:0]            addr_i,
  input  logic [DATA_WIDTH-1:0]            wdata_i,
  input  logic                             wr_rd_i,
  output logic                             ready_o,
  output logic                             done_o,
  output logic [DATA_WIDTH-1:0]            rdata_o,
  output logic                             trans_err_o,
  output logic [NUM_SLAVES-1:0]            pselx,
  output logic                             penable,
  output logic                             pwrite,
  output logic [ADDR_WIDTH-1:0]            paddr,
  output logic [DATA_WIDTH-1:0]            pwdata,
  input  logic [NUM_SLAVES-1:0]            pready,
  input  logic [NUM_SLAVES-1:0]            pslverr,
  input  logic [NUM_SLAVES*DATA_WIDTH-1:0] prdata,
  output apb_state_e                       state_dbg
);

  localparam int SEL_W = sel_width(NUM_SLAVES);
  localparam int IDX_W = (SEL_W > 0) ? SEL_W : 1;

  apb_state_e state_q, state_d;

  logic [ADDR_WIDTH-1:0] dec_addr;
  logic [IDX_W-1:0]      dec_idx;
  logic [NUM_SLAVES-1:0] dec_onehot;
  logic                  dec_err;

  logic                  sel_ready;
  logic                  sel_err;
  logic [DATA_WIDTH-1:0] sel_rdata;

  logic complete;
  logic abort;
  logic dec_fail;
  logic tmo_hit;

  // In IDLE the incoming address is decoded so the accept cycle can already
  // choose between SETUP and an immediate decode error; afterwards the held paddr.
  assign dec_addr = (state_q == IDLE) ? addr_i : paddr;

  apb_addr_decoder #(
    .ADDR_WIDTH (ADDR_WIDTH),
    .NUM_SLAVES (NUM_SLAVES),
    .IDX_W      (IDX_W)
  ) u_decoder (
    .addr    (dec_addr),
    .idx     (dec_idx),
    .onehot  (dec_onehot),
    .dec_err (dec_err)
  );

  assign sel_ready = |(pready & dec_onehot);
  assign sel_err   = |(pslverr & dec_onehot);

  always_comb begin
    sel_rdata = '0;
    for (int k = 0; k < NUM_SLAVES; k++) begin
      if (dec_idx == k[IDX_W-1:0]) sel_rdata = prdata[k*DATA_WIDTH +: DATA_WIDTH];
    end
  end

`ifdef APB_TIMEOUT_EN
  localparam int TMO_W = $clog2(TIMEOUT_CYCLES) + 1;
  logic [TMO_W-1:0] tmo_cnt;

  always_ff @(posedge pclk or negedge preset_n) begin
    if (!preset_n) begin
      tmo_cnt <= '0;
    end else if (state_q == SETUP) begin
      tmo_cnt <= '0;
    end else if (state_q == ACCESS && !sel_ready) begin
      tmo_cnt <= tmo_cnt + TMO_W'(1);
    end
  end

  assign tmo_hit = (tmo_cnt == TMO_W'(TIMEOUT_CYCLES - 1));
`else
  assign tmo_hit = 1'b0;
`endif

  always_ff @(posedge pclk or negedge preset_n) begin
    if (!preset_n) state_q <= IDLE;
    else           state_q <= state_d;
  end

  always_comb begin
    state_d  = state_q;
    pselx    = '0;
    penable  = 1'b0;
    ready_o  = 1'b0;
    complete = 1'b0;
    abort    = 1'b0;
    dec_fail = 1'b0;
    case (state_q)
      IDLE: begin
        ready_o = 1'b1;
        if (trans_i) begin
          if (dec_err) dec_fail = 1'b1;
          else         state_d  = SETUP;
        end
      end
      SETUP: begin
        pselx   = dec_onehot;
        state_d = ACCESS;
      end
      ACCESS: begin
        pselx   = dec_onehot;
        penable = 1'b1;
        // A late pready wins over a simultaneous timeout.
        if (sel_ready) begin
          complete = 1'b1;
          state_d  = IDLE;
        end else if (tmo_hit) begin
          abort   = 1'b1;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge pclk or negedge preset_n) begin
    if (!preset_n) begin
      done_o      <= 1'b0;
      trans_err_o <= 1'b0;
      rdata_o     <= '0;
      paddr       <= '0;
      pwdata      <= '0;
      pwrite      <= 1'b0;
    end else begin
      done_o      <= complete | abort | dec_fail;
      trans_err_o <= (complete & sel_err) | abort | dec_fail;
      if (state_q == IDLE && trans_i) begin
        paddr  <= addr_i;
        pwdata <= wdata_i;
        pwrite <= wr_rd_i;
      end
      if (complete && !pwrite && !sel_err) rdata_o <= sel_rdata;
    end
  end

  assign state_dbg = state_q;

endmodule

// File: tb/tb_apb_master_bridge.sv
// Directed self-checking bench for apb_master_bridge: a 4-slave instance for the
// transfer scenarios and a 3-slave instance for decode errors.
module tb_apb_master_bridge;
  import apb_pkg::*;

  localparam int AW = 32;
  localparam int DW = 32;

  // Clock / reset
  logic pclk = 1'b0;
  logic preset_n = 1'b0;
  always #5 pclk = ~pclk;

  // Four-slave instance
  logic          trans = 1'b0, wr_rd = 1'b0;
  logic [AW-1:0] addr = '0;
  logic [DW-1:0] wdata = '0;
  logic          ready, done, terr, penable, pwrite;
  logic [DW-1:0] rdata, pwdata;
  logic [AW-1:0] paddr;
  logic [3:0]    pselx, pready = '0, pslverr = '0;
  logic [4*DW-1:0] prdata = '0;
  apb_state_e    state4;

  // Three-slave instance
  logic          d3_trans = 1'b0, d3_wr_rd = 1'b0;
  logic [AW-1:0] d3_addr = '0;
  logic [DW-1:0] d3_wdata = '0;
  logic          d3_ready, d3_done, d3_terr, d3_penable, d3_pwrite;
  logic [DW-1:0] d3_rdata, d3_pwdata;
  logic [AW-1:0] d3_paddr;
  logic [2:0]    d3_pselx, d3_pready = '0, d3_pslverr = '0;
  logic [3*DW-1:0] d3_prdata = '0;
  apb_state_e    state3;

  int checks = 0;
  int failures = 0;
  logic [DW-1:0] exp_q[$];
  logic [DW-1:0] exp_v;

  apb_master_bridge #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .NUM_SLAVES(4), .TIMEOUT_CYCLES(8)) u_dut4 (
    .pclk(pclk), .preset_n(preset_n), .trans_i(trans), .addr_i(addr), .wdata_i(wdata),
    .wr_rd_i(wr_rd), .ready_o(ready), .done_o(done), .rdata_o(rdata), .trans_err_o(terr),
    .pselx(pselx), .penable(penable), .pwrite(pwrite), .paddr(paddr), .pwdata(pwdata),
    .pready(pready), .pslverr(pslverr), .prdata(prdata), .state_dbg(state4)
  );

  apb_master_bridge #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .NUM_SLAVES(3), .TIMEOUT_CYCLES(8)) u_dut3 (
    .pclk(pclk), .preset_n(preset_n), .trans_i(d3_trans), .addr_i(d3_addr), .wdata_i(d3_wdata),
    .wr_rd_i(d3_wr_rd), .ready_o(d3_ready), .done_o(d3_done), .rdata_o(d3_rdata), .trans_err_o(d3_terr),
    .pselx(d3_pselx), .penable(d3_penable), .pwrite(d3_pwrite), .paddr(d3_paddr), .pwdata(d3_pwdata),
    .pready(d3_pready), .pslverr(d3_pslverr), .prdata(d3_prdata), .state_dbg(state3)
  );

  // Driver: present a request on the four-slave instance (call at a negedge).
  task automatic drive_req(input logic [AW-1:0] a, input logic [DW-1:0] d, input logic w);
    trans = 1'b1; addr = a; wdata = d; wr_rd = w;
  endtask

  task automatic drop_req();
    trans = 1'b0; addr = '0; wdata = '0; wr_rd = 1'b0;
  endtask

  task automatic test_reset();
    preset_n = 1'b0;
    repeat (2) @(negedge pclk);
    checks++; if (ready !== 1'b1) begin failures++; $display("FAIL rst_ready got=%b exp=1", ready); end
    checks++; if (pselx !== 4'b0000 || penable !== 1'b0 || pwrite !== 1'b0) begin failures++; $display("FAIL rst_apb_ctrl got=%b/%b/%b exp=0000/0/0", pselx, penable, pwrite); end
    checks++; if (paddr !== '0 || pwdata !== '0) begin failures++; $display("FAIL rst_apb_data got=%h/%h exp=0/0", paddr, pwdata); end
    checks++; if (done !== 1'b0 || terr !== 1'b0 || rdata !== '0) begin failures++; $display("FAIL rst_resp got=%b/%b/%h exp=0/0/0", done, terr, rdata); end
    checks++; if (state4 !== IDLE || state3 !== IDLE) begin failures++; $display("FAIL rst_state got=%0d/%0d exp=0/0", state4, state3); end
    checks++; if (d3_ready !== 1'b1 || d3_pselx !== 3'b000) begin failures++; $display("FAIL rst_d3 got=%b/%b exp=1/000", d3_ready, d3_pselx); end
    preset_n = 1'b1;
    @(negedge pclk);
  endtask

  task automatic test_zero_wait_write();
    pready = 4'b0010;
    drive_req(32'h4000_0010, 32'hDEAD_BEEF, 1'b1);       // T0
    @(negedge pclk); drop_req();                          // T1 SETUP
    checks++; if (pselx !== 4'b0010 || penable !== 1'b0) begin failures++; $display("FAIL wr_setup got=%b/%b exp=0010/0", pselx, penable); end
    checks++; if (paddr !== 32'h4000_0010 || pwdata !== 32'hDEAD_BEEF || pwrite !== 1'b1) begin failures++; $display("FAIL wr_bus got=%h/%h/%b", paddr, pwdata, pwrite); end
    checks++; if (ready !== 1'b0) begin failures++; $display("FAIL wr_busy got=%b exp=0", ready); end
    @(negedge pclk);                                      // T2 ACCESS
    checks++; if (pselx !== 4'b0010 || penable !== 1'b1 || done !== 1'b0) begin failures++; $display("FAIL wr_access got=%b/%b/%b exp=0010/1/0", pselx, penable, done); end
    @(negedge pclk);                                      // T3 done
    checks++; if (done !== 1'b1 || terr !== 1'b0 || ready !== 1'b1) begin failures++; $display("FAIL wr_done got=%b/%b/%b exp=1/0/1", done, terr, ready); end
    checks++; if (rdata !== 32'h0 || pselx !== 4'b0000) begin failures++; $display("FAIL wr_after got=%h/%b exp=0/0000", rdata, pselx); end
    checks++; if (paddr !== 32'h4000_0010) begin failures++; $display("FAIL wr_hold got=%h exp=40000010", paddr); end
    @(negedge pclk);
    checks++; if (done !== 1'b0) begin failures++; $display("FAIL wr_pulse got=%b exp=0", done); end
    pready = '0;
  endtask

  task automatic test_read_waits();
    // Distractors on unselected slaves must be ignored.
    pready = 4'b0001; pslverr = 4'b1000;
    prdata = {32'h0, 32'h1234_5678, 32'h0, 32'hFFFF_FFFF};
    exp_q.push_back(32'h1234_5678);
    drive_req(32'h8000_0000, 32'h0, 1'b0);               // T0
    @(negedge pclk); drop_req();                          // T1
    checks++; if (pselx !== 4'b0100 || penable !== 1'b0) begin failures++; $display("FAIL rd_setup got=%b/%b exp=0100/0", pselx, penable); end
    for (int i = 0; i < 4; i++) begin                     // T2..T5
      @(negedge pclk);
      checks++; if (penable !== 1'b1 || pselx !== 4'b0100 || done !== 1'b0) begin failures++; $display("FAIL rd_wait%0d got=%b/%b/%b exp=1/0100/0", i, penable, pselx, done); end
      if (i == 3) pready = 4'b0101;
    end
    @(negedge pclk);                                      // T6
    exp_v = exp_q.pop_front();
    checks++; if (done !== 1'b1 || terr !== 1'b0) begin failures++; $display("FAIL rd_done got=%b/%b exp=1/0", done, terr); end
    checks++; if (rdata !== exp_v) begin failures++; $display("FAIL rd_data got=%h exp=%h", rdata, exp_v); end
    pready = '0; pslverr = '0;
    @(negedge pclk);
  endtask

  task automatic test_slave_error();
    pready = 4'b0001; pslverr = 4'b0001;
    prdata = {96'h0, 32'hAAAA_5555};
    drive_req(32'h0000_0020, 32'h0, 1'b0);
    @(negedge pclk); drop_req();
    checks++; if (pselx !== 4'b0001) begin failures++; $display("FAIL err_sel got=%b exp=0001", pselx); end
    @(negedge pclk);
    @(negedge pclk);
    checks++; if (done !== 1'b1 || terr !== 1'b1) begin failures++; $display("FAIL err_done got=%b/%b exp=1/1", done, terr); end
    checks++; if (rdata !== 32'h1234_5678) begin failures++; $display("FAIL err_rdata got=%h exp=12345678", rdata); end
    @(negedge pclk);
    checks++; if (done !== 1'b0 || terr !== 1'b0) begin failures++; $display("FAIL err_clear got=%b/%b exp=0/0", done, terr); end
    pready = '0; pslverr = '0;
  endtask

  task automatic test_back_to_back();
    pready = 4'b1000;
    prdata = {32'h5A5A_0003, 96'h0};
    drive_req(32'hC000_0004, 32'h0000_CAFE, 1'b1);       // T0
    @(negedge pclk); drop_req();                          // T1
    @(negedge pclk);                                      // T2
    @(negedge pclk);                                      // T3: done, accept next
    checks++; if (done !== 1'b1 || ready !== 1'b1) begin failures++; $display("FAIL b2b_done got=%b/%b exp=1/1", done, ready); end
    drive_req(32'hC000_0008, 32'h0, 1'b0);
    @(negedge pclk); drop_req();                          // T4 SETUP
    checks++; if (pselx !== 4'b1000 || penable !== 1'b0 || pwrite !== 1'b0 || paddr !== 32'hC000_0008) begin failures++; $display("FAIL b2b_setup got=%b/%b/%b/%h", pselx, penable, pwrite, paddr); end
    checks++; if (done !== 1'b0) begin failures++; $display("FAIL b2b_pulse got=%b exp=0", done); end
    @(negedge pclk);                                      // T5
    @(negedge pclk);                                      // T6
    checks++; if (done !== 1'b1 || rdata !== 32'h5A5A_0003) begin failures++; $display("FAIL b2b_rd got=%b/%h exp=1/5a5a0003", done, rdata); end
    pready = '0;
    @(negedge pclk);
  endtask

  task automatic test_reset_mid_access();
    drive_req(32'h8000_0040, 32'h0, 1'b0);
    @(negedge pclk); drop_req();
    @(negedge pclk);
    checks++; if (penable !== 1'b1) begin failures++; $display("FAIL rma_access got=%b exp=1", penable); end
    @(negedge pclk);
    preset_n = 1'b0;
    #1;
    checks++; if (pselx !== 4'b0000 || penable !== 1'b0 || ready !== 1'b1) begin failures++; $display("FAIL rma_ctrl got=%b/%b/%b exp=0000/0/1", pselx, penable, ready); end
    checks++; if (rdata !== '0 || paddr !== '0 || done !== 1'b0) begin failures++; $display("FAIL rma_regs got=%h/%h/%b exp=0/0/0", rdata, paddr, done); end
    @(negedge pclk); preset_n = 1'b1;
    @(negedge pclk);
    checks++; if (done !== 1'b0 || ready !== 1'b1) begin failures++; $display("FAIL rma_nodone got=%b/%b exp=0/1", done, ready); end
    pready = 4'b0010;
    drive_req(32'h4000_0000, 32'h0000_0011, 1'b1);
    @(negedge pclk); drop_req();
    @(negedge pclk);
    @(negedge pclk);
    checks++; if (done !== 1'b1 || terr !== 1'b0 || pwdata !== 32'h0000_0011) begin failures++; $display("FAIL rma_clean got=%b/%b/%h exp=1/0/11", done, terr, pwdata); end
    pready = '0;
    @(negedge pclk);
  endtask

`ifdef APB_TIMEOUT_EN
  task automatic test_timeout();
    drive_req(32'h4000_0000, 32'h0, 1'b0);               // T0
    @(negedge pclk); drop_req();                          // T1
    for (int i = 0; i < 8; i++) begin                     // T2..T9
      @(negedge pclk);
      checks++; if (pselx !== 4'b0010 || penable !== 1'b1 || done !== 1'b0) begin failures++; $display("FAIL tmo_wait%0d got=%b/%b/%b exp=0010/1/0", i, pselx, penable, done); end
    end
    @(negedge pclk);                                      // T10
    checks++; if (pselx !== 4'b0000 || done !== 1'b1 || terr !== 1'b1) begin failures++; $display("FAIL tmo_abort got=%b/%b/%b exp=0000/1/1", pselx, done, terr); end
    checks++; if (rdata !== '0) begin failures++; $display("FAIL tmo_rdata got=%h exp=0", rdata); end
    @(negedge pclk);
  endtask
`else
  task automatic test_timeout();
    prdata = {64'h0, 32'h0BAD_F00D, 32'h0};
    drive_req(32'h4000_0000, 32'h0, 1'b0);
    @(negedge pclk); drop_req();
    for (int i = 0; i < 13; i++) begin
      @(negedge pclk);
      checks++; if (penable !== 1'b1 || done !== 1'b0) begin failures++; $display("FAIL long_wait%0d got=%b/%b exp=1/0", i, penable, done); end
      if (i == 12) pready = 4'b0010;
    end
    @(negedge pclk);
    checks++; if (done !== 1'b1 || terr !== 1'b0 || rdata !== 32'h0BAD_F00D) begin failures++; $display("FAIL long_done got=%b/%b/%h exp=1/0/0badf00d", done, terr, rdata); end
    pready = '0;
    @(negedge pclk);
  endtask
`endif

  task automatic test_decode_error();
    d3_trans = 1'b1; d3_addr = 32'hC000_0000; d3_wr_rd = 1'b0;   // T0
    @(negedge pclk); d3_trans = 1'b0; d3_addr = '0;             // T1
    checks++; if (d3_done !== 1'b1 || d3_terr !== 1'b1) begin failures++; $display("FAIL dec_done got=%b/%b exp=1/1", d3_done, d3_terr); end
    checks++; if (d3_pselx !== 3'b000 || d3_ready !== 1'b1 || state3 !== IDLE) begin failures++; $display("FAIL dec_idle got=%b/%b/%0d exp=000/1/0", d3_pselx, d3_ready, state3); end
    @(negedge pclk);
    checks++; if (d3_done !== 1'b0 || d3_terr !== 1'b0 || d3_pselx !== 3'b000) begin failures++; $display("FAIL dec_clear got=%b/%b/%b exp=0/0/000", d3_done, d3_terr, d3_pselx); end
    d3_pready = 3'b100; d3_prdata = {32'h0000_0C02, 64'h0};
    d3_trans = 1'b1; d3_addr = 32'h8000_0000;
    @(negedge pclk); d3_trans = 1'b0; d3_addr = '0;
    checks++; if (d3_pselx !== 3'b100) begin failures++; $display("FAIL dec_valid_sel got=%b exp=100", d3_pselx); end
    @(negedge pclk);
    @(negedge pclk);
    checks++; if (d3_done !== 1'b1 || d3_terr !== 1'b0 || d3_rdata !== 32'h0000_0C02) begin failures++; $display("FAIL dec_valid_done got=%b/%b/%h exp=1/0/00000c02", d3_done, d3_terr, d3_rdata); end
    d3_pready = '0;
    @(negedge pclk);
  endtask

  initial begin
    test_reset();
    test_zero_wait_write();
    test_read_waits();
    test_slave_error();
    test_back_to_back();
    test_decode_error();
    test_reset_mid_access();
    test_timeout();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/apb_master_bridge.md
# apb_master_bridge

Parametrised APB3 master bridge between the system-side request port and up to NUM_SLAVES APB completers. Accepts one request at a time, decodes the address to a single pselx line, runs the SETUP/ACCESS protocol with unlimited wait states, and returns read data and an error flag to the requester. It adds per-slave select decode, a ready/done handshake toward the bridge and an optional access timeout.

## Interface
Parameters:
- ADDR_WIDTH, 32, address width.
- DATA_WIDTH, 32, data width.
- NUM_SLAVES, 4, number of completers (1..16).
- TIMEOUT_CYCLES, 256, ACCESS cycles before abort (only with timeout compiled in).

Ports:
- pclk  in  1  APB clock; the only clock.
- preset_n  in  1  asynchronous, active-low reset.
- trans_i  in  1  request valid from bridge.
- addr_i  in  ADDR_WIDTH  request address.
- wdata_i  in  DATA_WIDTH  write data.
- wr_rd_i  in  1  1 = write, 0 = read.
- ready_o  out  1  bridge may present a request (IDLE).
- done_o  out  1  one-cycle completion pulse.
- rdata_o  out  DATA_WIDTH  read data of the last successful read.
- trans_err_o  out  1  error status, valid with done_o.
- pselx  out  NUM_SLAVES  one-hot select.
- penable  out  1  APB enable.
- pwrite  out  1  APB direction.
- paddr  out  ADDR_WIDTH  APB address.
- pwdata  out  DATA_WIDTH  APB write data.
- pready  in  NUM_SLAVES  per-slave ready.
- pslverr  in  NUM_SLAVES  per-slave error.
- prdata  in  NUM_SLAVES*DATA_WIDTH  per-slave read data, slave k at [k*DATA_WIDTH +: DATA_WIDTH].

## Operation
- FSM states: IDLE, SETUP, ACCESS. Reset enters IDLE.
- IDLE: ready_o=1. If trans_i=1, capture addr_i, wdata_i and wr_rd_i into paddr, pwdata and pwrite, then decode.
- Decode: SEL_W=$clog2(NUM_SLAVES) (0 when NUM_SLAVES=1). The index is paddr[ADDR_WIDTH-1 -: SEL_W].
  - Index < NUM_SLAVES: go to SETUP.
  - Index >= NUM_SLAVES: decode error. Stay in IDLE, no pselx, and the next cycle gives done_o=1 with trans_err_o=1.
- SETUP: pselx[idx]=1, penable=0. Next state is always ACCESS.
- ACCESS: pselx[idx]=1, penable=1. Hold until pready[idx]=1, then go to IDLE.
- On completion, register trans_err_o=pslverr[idx].
- On a read with no error, register rdata_o=prdata slice idx.
- Writes and errored transfers leave rdata_o unchanged.
- Only the selected slave's pready, pslverr and prdata are observed. All others are ignored.
- paddr, pwrite and pwdata stay stable from SETUP through ACCESS and hold their last value in IDLE.
- trans_i in non-IDLE states is ignored. The bridge must hold the request until ready_o=1.

## Timing
- Reset values:
  - ready_o=1.
  - pselx, penable, pwrite, paddr, pwdata, done_o, rdata_o and trans_err_o are all 0.
- Reset is asynchronous mid-transfer. The in-flight transfer is dropped and no done_o is produced.
- Zero-wait transfer: accept at T0, SETUP at T1, ACCESS with pready at T2, done_o at T3 (with ready_o=1), next accept at T3.
- Each wait cycle adds one cycle. done_o is exactly one cycle wide.
- Decode error: accept at T0, done_o and trans_err_o at T1.
- trans_err_o is meaningful only while done_o=1; otherwise it is 0.

## Configuration
- APB_TIMEOUT_EN defined:
  - A counter clears on SETUP and increments for each ACCESS cycle with pready[idx]=0.
  - When the count reaches TIMEOUT_CYCLES-1 and pready is still low, the FSM drops pselx and penable and returns to IDLE.
  - done_o=1 and trans_err_o=1 on the next cycle; rdata_o is unchanged.
  - pready arriving in the same cycle as the abort counts as a normal completion.
- APB_TIMEOUT_EN undefined: no counter, ACCESS waits indefinitely, and TIMEOUT_CYCLES is unused.

## Structure
- Shared package apb_pkg holds:
  - the state enum apb_state_e (IDLE, SETUP, ACCESS);
  - default ADDR_WIDTH and DATA_WIDTH constants;
  - a function sel_width(n) returning $clog2 with a minimum of 0.
- Sub-module apb_addr_decoder is combinational. It takes paddr and produces the index, the one-hot vector and the decode-error flag.

## Test plan
- Zero-wait write: addr 0x4000_0010 with NUM_SLAVES=4 (slave 1), wdata 0xDEAD_BEEF, pready[1]=1 at ACCESS. Expect:
  - pselx=4'b0010;
  - penable low at T1 and high at T2;
  - done_o at T3, trans_err_o=0, rdata_o unchanged.
- Read with 3 wait states: slave 2 returns 0x1234_5678. Expect ACCESS held 4 cycles, done_o at T6 and rdata_o=0x1234_5678.
- Slave error: pslverr[0]=1 with pready on a read. Expect trans_err_o=1 with done_o and rdata_o unchanged.
- Decode error: NUM_SLAVES=3 with address index 3. Expect pselx never asserted, and done_o with trans_err_o=1 one cycle after accept.
- Timeout: APB_TIMEOUT_EN defined, TIMEOUT_CYCLES=8, pready held low. Expect pselx to drop after 8 ACCESS cycles, then done_o with trans_err_o=1.
- Reset mid-ACCESS: assert preset_n=0 during a wait state. Expect all outputs at reset values immediately, no done_o, and a clean next transfer.
